// File: rtl/l2_read_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 read channels around l2_read_arbiter.
// The master modport is the arbiter's view; slave is the caches/L2 side.
interface l2_read_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int BUS_W  = 128
);
  logic              INS_ADDR_VALID;
  logic              INS_ADDR_READY;
  logic [ADDR_W-1:0] INS_ADDR;
  logic              INS_DATA_VALID;
  logic              INS_DATA_READY;
  logic [BUS_W-1:0]  INS_DATA;

  logic              DAT_ADDR_VALID;
  logic              DAT_ADDR_READY;
  logic [ADDR_W-1:0] DAT_ADDR;
  logic              DAT_DATA_VALID;
  logic              DAT_DATA_READY;
  logic [BUS_W-1:0]  DAT_DATA;

  logic              L2_ADDR_VALID;
  logic              L2_ADDR_READY;
  logic [ADDR_W-1:0] L2_ADDR;
  logic              L2_DATA_VALID;
  logic              L2_DATA_READY;
  logic [BUS_W-1:0]  L2_DATA;

  modport master (
    input  INS_ADDR_VALID, INS_ADDR, INS_DATA_READY,
    output INS_ADDR_READY, INS_DATA_VALID, INS_DATA,
    input  DAT_ADDR_VALID, DAT_ADDR, DAT_DATA_READY,
    output DAT_ADDR_READY, DAT_DATA_VALID, DAT_DATA,
    output L2_ADDR_VALID, L2_ADDR, L2_DATA_READY,
    input  L2_ADDR_READY, L2_DATA_VALID, L2_DATA
  );

  modport slave (
    output INS_ADDR_VALID, INS_ADDR, INS_DATA_READY,
    input  INS_ADDR_READY, INS_DATA_VALID, INS_DATA,
    output DAT_ADDR_VALID, DAT_ADDR, DAT_DATA_READY,
    input  DAT_ADDR_READY, DAT_DATA_VALID, DAT_DATA,
    input  L2_ADDR_VALID, L2_ADDR, L2_DATA_READY,
    output L2_ADDR_READY, L2_DATA_VALID, L2_DATA
  );
endinterface

// File: rtl/l2_read_arbiter.sv
// Round-robin sharing of the L2 read path between I-cache and D-cache, with an
// in-order owner queue steering each returning burst to the cache that issued it.
module l2_read_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int BUS_W   = 128,
  parameter int BURST   = 4,
  parameter int ORD_LOG = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  l2_read_arbiter_if.master  bus,
  output logic               ERR
);
  localparam int DEPTH  = 1 << ORD_LOG;
  localparam int CNT_W  = ORD_LOG + 1;
  localparam int BEAT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   l2_addr_reg;
  logic                l2_addr_valid_reg;
  logic                owner_reg;
  logic                last_grant_reg;
  logic                owner_q_reg [DEPTH];
  logic [ORD_LOG-1:0]  wr_ptr_reg;
  logic [ORD_LOG-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic                err_reg;

  logic q_empty, q_full, head_owner;
  logic grant, grant_dat, push, pop, beat_hs;

  assign q_empty    = (count_reg == '0);
  assign q_full     = (count_reg == CNT_W'(DEPTH));
  assign head_owner = owner_q_reg[rd_ptr_reg];

  // On a tie the requester not granted last wins; last_grant_reg=1 means DAT.
  assign grant_dat = bus.DAT_ADDR_VALID && (!bus.INS_ADDR_VALID || !last_grant_reg);
  assign grant     = (state_reg == IDLE) && !q_full &&
                     (bus.INS_ADDR_VALID || bus.DAT_ADDR_VALID);

  assign bus.INS_ADDR_READY = grant && !grant_dat;
  assign bus.DAT_ADDR_READY = grant && grant_dat;
  assign bus.L2_ADDR_VALID  = l2_addr_valid_reg;
  assign bus.L2_ADDR        = l2_addr_reg;

  assign push = (state_reg == ISSUE) && bus.L2_ADDR_READY;

  // Zero-latency steering: the queue head picks the destination cache.
  assign bus.INS_DATA_VALID = !q_empty && !head_owner && bus.L2_DATA_VALID;
  assign bus.DAT_DATA_VALID = !q_empty &&  head_owner && bus.L2_DATA_VALID;
  assign bus.L2_DATA_READY  = !q_empty &&
                              (head_owner ? bus.DAT_DATA_READY : bus.INS_DATA_READY);
  assign bus.INS_DATA       = bus.L2_DATA;
  assign bus.DAT_DATA       = bus.L2_DATA;

  assign beat_hs = bus.L2_DATA_VALID && bus.L2_DATA_READY;
  assign pop     = beat_hs && (beat_cnt_reg == BEAT_W'(BURST - 1));

  assign ERR = err_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg         <= IDLE;
      l2_addr_reg       <= '0;
      l2_addr_valid_reg <= 1'b0;
      owner_reg         <= 1'b0;
      last_grant_reg    <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            l2_addr_reg       <= grant_dat ? bus.DAT_ADDR : bus.INS_ADDR;
            l2_addr_valid_reg <= 1'b1;
            owner_reg         <= grant_dat;
            last_grant_reg    <= grant_dat;
            state_reg         <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.L2_ADDR_READY) begin
            l2_addr_valid_reg <= 1'b0;
            state_reg         <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      owner_q_reg[wr_ptr_reg] <= owner_reg;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (pop) begin
        beat_cnt_reg <= '0;
      end else if (beat_hs) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
      if (q_empty && bus.L2_DATA_VALID) begin
        err_reg <= 1'b1;
      end
    end
  end
endmodule
